// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: fetches at PC, issues a one-cycle pulse to the core,
// and speculatively prefetches PC+4 while the core executes.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              in_valid,
  output logic [DATA_W-1:0] inst,
  input  logic              out_valid,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              err
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_PF, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pf_addr_q, pf_addr_d, npc_q, npc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d, inst_q, inst_d;
  logic              pend_q, pend_d, in_valid_q, in_valid_d;
  logic              mem_req_q, mem_req_d, err_q, err_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

  logic              ack, hit, take;
  logic [ADDR_W-1:0] ov_addr, tgt;
  logic [DATA_W-1:0] issue_word;

  // Acks are only meaningful while our request is actually on the bus.
  assign ack     = mem_ack & mem_req_q;
  assign ov_addr = {inst_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    npc_d      = npc_q;
    pend_d     = pend_q;
    hit        = 1'b0;
    issue_word = inst_q;
    take       = pend_q;
    tgt        = npc_q;
    err_d      = err_q | (out_valid & (inst_addr[1:0] != 2'b00));
    case (state_q)
      S_FETCH: begin
        if (out_valid) err_d = 1'b1;
        if (ack) begin
          issue_word = mem_rdata;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (out_valid) err_d = 1'b1;
        pf_addr_d = pc_q + ADDR_W'(4);
        state_d   = S_PF;
      end
      S_PF: begin
        // A retire arriving with the ack counts as already pending.
        if (out_valid && pend_q) err_d = 1'b1;
        else if (out_valid) begin
          pend_d = 1'b1;
          npc_d  = ov_addr;
          take   = 1'b1;
          tgt    = ov_addr;
        end
        if (ack) begin
          pf_data_d = mem_rdata;
          pend_d    = 1'b0;
          if (take) begin
            pc_d = tgt;
            if (tgt == pf_addr_q) begin
              hit        = 1'b1;
              issue_word = mem_rdata;
              state_d    = S_ISSUE;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_valid) begin
          pc_d = ov_addr;
          if (ov_addr == pf_addr_q) begin
            hit        = 1'b1;
            issue_word = pf_data_q;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    in_valid_d = (state_d == S_ISSUE);
    inst_d     = in_valid_d ? issue_word : inst_q;
    mem_req_d  = (state_d == S_FETCH) || (state_d == S_PF);
    mem_addr_d = mem_addr_q;
    if (state_d == S_FETCH)   mem_addr_d = pc_d;
    else if (state_d == S_PF) mem_addr_d = pf_addr_d;
    hit_cnt_d = hit_cnt_q;
    if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      npc_q      <= '0;
      pend_q     <= 1'b0;
      in_valid_q <= 1'b0;
      inst_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      npc_q      <= npc_d;
      pend_q     <= pend_d;
      in_valid_q <= in_valid_d;
      inst_q     <= inst_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      err_q      <= err_d;
    end
  end

  assign in_valid = in_valid_q;
  assign inst     = inst_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: latency-programmable memory, scripted core, vector
// table, random instruction stream and reset/protocol corner cases.
`timescale 1ns/1ps
module tb_inst_fetch_unit;
  localparam int AW = 32, DW = 32, CW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid, mem_req, mem_ack, err;
  logic [DW-1:0] inst, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] hit_cnt;
  logic          out_valid = 1'b0;
  logic [AW-1:0] inst_addr = '0;

  logic          resp_ack = 1'b0, mem_en = 1'b1, stale_ack = 1'b0;
  logic [DW-1:0] resp_data = '0;
  int            lat = 2, cnt = 0;
  int            n_chk = 0, n_fail = 0, exp_hits = 0;
  logic          exp_err = 1'b0, snap_req = 1'b0;
  logic [AW-1:0] snap_addr = '0, pc = '0;

  typedef struct {int lat; int d; logic [31:0] tgt; bit hit; int gap;} vec_t;
  vec_t tbl[18];

  assign mem_ack   = mem_en ? resp_ack  : stale_ack;
  assign mem_rdata = mem_en ? resp_data : 32'hDEADBEEF;

  inst_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst),
    .out_valid(out_valid), .inst_addr(inst_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .err(err));

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0C010005;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Cycles from one in_valid to the next, given memory latency l and core delay d.
  function automatic int gapf(input int l, input int d, input bit h);
    if (h) return (d <= l) ? l + 1 : d + 1;
    return (d <= l) ? 2 * l + 2 : d + l + 1;
  endfunction

  // Memory: acks l cycles into a request, then rests one cycle.
  initial forever begin
    @(negedge clk);
    if (resp_ack) begin resp_ack = 1'b0; cnt = 0; end
    else if (mem_req) begin
      cnt++;
      if (cnt >= lat) begin resp_ack = 1'b1; resp_data = memword(mem_addr); end
    end else cnt = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; out_valid = 1'b0; mem_en = 1'b1; stale_ack = 1'b0; lat = 2;
    repeat (3) @(negedge clk);
    chk("rst in_valid", 64'(in_valid), 64'd0);
    chk("rst inst", 64'(inst), 64'd0);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    exp_hits = 0; exp_err = 1'b0; pc = '0;
    rst = 1'b0;
  endtask

  task automatic first_fetch(input bit inject);
    int k;
    @(negedge clk);
    chk("first mem_req", 64'(mem_req), 64'd1);
    chk("first mem_addr", 64'(mem_addr), 64'd0);
    if (inject) begin out_valid = 1'b1; inst_addr = 32'h40; end
    @(negedge clk);
    out_valid = 1'b0;
    if (inject) begin
      exp_err = 1'b1;
      chk("fetch ov err", 64'(err), 64'd1);
      chk("fetch ov addr", 64'(mem_addr), 64'd0);
      chk("fetch ov req", 64'(mem_req), 64'd1);
    end
    k = 2;
    while (k < 40 && !in_valid) begin @(negedge clk); k++; end
    chk("first gap", 64'(k), 64'd3);
    chk("first inst", 64'(inst), 64'(32'h0C010005));
  endtask

  // Entered at the negedge where in_valid is seen; returns at the next in_valid.
  task automatic step(input string nm, input int l, input int d, input logic [31:0] tgt,
                      input bit ehit, input int egap);
    int k; bit seen;
    logic [31:0] ta;
    ta = {tgt[31:2], 2'b00};
    if (ehit) exp_hits++;
    lat = l; seen = 1'b0; k = 0;
    while (!seen && k < 80) begin
      @(negedge clk); k++;
      if (k == 1) chk({nm, " pulse"}, 64'(in_valid), 64'd0);
      if (k == d + 1) begin snap_req = mem_req; snap_addr = mem_addr; end
      if (k > 1 && in_valid) seen = 1'b1;
      else begin
        out_valid = (k == d);
        if (k == d) inst_addr = tgt;
      end
    end
    out_valid = 1'b0;
    chk({nm, " seen"}, 64'(seen), 64'd1);
    chk({nm, " gap"}, 64'(k), 64'(egap));
    chk({nm, " inst"}, 64'(inst), 64'(memword(ta)));
    chk({nm, " hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
    chk({nm, " err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    int k;
    logic [31:0] t;
    bit h;
    int l, d;
    tbl[0]  = '{2, 4, 32'h04, 1'b1, 5};
    tbl[1]  = '{2, 2, 32'h08, 1'b1, 3};
    tbl[2]  = '{1, 1, 32'h0C, 1'b1, 2};
    tbl[3]  = '{3, 1, 32'h10, 1'b1, 4};
    tbl[4]  = '{3, 5, 32'h14, 1'b1, 6};
    tbl[5]  = '{1, 3, 32'h18, 1'b1, 4};
    tbl[6]  = '{2, 1, 32'h1C, 1'b1, 3};
    tbl[7]  = '{2, 3, 32'h20, 1'b1, 4};
    tbl[8]  = '{4, 2, 32'h24, 1'b1, 5};
    tbl[9]  = '{1, 2, 32'h28, 1'b1, 3};
    tbl[10] = '{2, 5, 32'h40, 1'b0, 8};
    tbl[11] = '{6, 2, 32'h44, 1'b1, 7};
    tbl[12] = '{6, 3, 32'h20, 1'b0, 14};
    tbl[13] = '{1, 1, 32'h24, 1'b1, 2};
    tbl[14] = '{2, 2, 32'h100, 1'b0, 6};
    tbl[15] = '{3, 6, 32'h200, 1'b0, 10};
    tbl[16] = '{2, 3, 32'hFFFFFFFC, 1'b0, 6};
    tbl[17] = '{2, 4, 32'h0, 1'b1, 5};

    do_reset();
    first_fetch(1'b0);
    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), tbl[i].lat, tbl[i].d, tbl[i].tgt, tbl[i].hit, tbl[i].gap);
      pc = tbl[i].tgt;
      if (i == 9) chk("ten seq hits", 64'(hit_cnt), 64'd10);
    end

    for (int i = 0; i < 40; i++) begin
      l = int'($urandom_range(1, 5));
      d = int'($urandom_range(1, 8));
      t = $urandom_range(0, 1) ? pc + 32'd4 : (32'($urandom_range(0, 1023)) << 2);
      h = (t == pc + 32'd4);
      step($sformatf("rnd%0d", i), l, d, t, h, gapf(l, d, h));
      pc = t;
    end

    // out_valid during FETCH is flagged and otherwise ignored
    do_reset();
    first_fetch(1'b1);
    step("after fetch ov", 2, 4, 32'h4, 1'b1, 5);

    // misaligned next PC is fetched with low bits cleared
    do_reset();
    first_fetch(1'b0);
    step("pre misalign", 2, 4, 32'h4, 1'b1, 5);
    exp_err = 1'b1;
    step("misalign", 2, 5, 32'h6, 1'b0, 8);
    chk("misalign req", 64'(snap_req), 64'd1);
    chk("misalign addr", 64'(snap_addr), 64'h4);

    // reset while a fetch of 0x40 is outstanding
    do_reset();
    first_fetch(1'b0);
    repeat (4) @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);
    out_valid = 1'b1; inst_addr = 32'h40;
    @(negedge clk);
    out_valid = 1'b0;
    chk("hang req", 64'(mem_req), 64'd1);
    chk("hang addr", 64'(mem_addr), 64'h40);
    repeat (2) @(negedge clk);
    chk("hang req held", 64'(mem_req), 64'd1);
    chk("hang addr held", 64'(mem_addr), 64'h40);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst req", 64'(mem_req), 64'd0);
    chk("midrst in_valid", 64'(in_valid), 64'd0);
    chk("midrst addr", 64'(mem_addr), 64'd0);
    rst = 1'b0; stale_ack = 1'b1;
    @(negedge clk);
    stale_ack = 1'b0; mem_en = 1'b1;
    chk("restart req", 64'(mem_req), 64'd1);
    chk("restart addr", 64'(mem_addr), 64'd0);
    chk("stale ignored", 64'(in_valid), 64'd0);
    k = 0;
    while (k < 40) begin
      @(negedge clk); k++;
      if (in_valid) break;
    end
    chk("restart gap", 64'(k), 64'd2);
    chk("restart inst", 64'(inst), 64'(32'h0C010005));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle core. It fetches the instruction at the current PC from instruction memory and hands it to the core as a one-cycle `in_valid`/`inst` pulse. It then waits for the core's `out_valid`/`inst_addr` (next PC) to start the next fetch. While the core executes, it speculatively prefetches PC+4 into a one-entry buffer, so sequential instructions issue one cycle after `out_valid` instead of paying a full memory round trip.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `DATA_W`, 32, instruction width
- `RESET_PC`, 0, address fetched first after reset
- `CNT_W`, 16, width of prefetch-hit counter
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  out  1  one-cycle pulse: `inst` valid for the core
- `inst`  out  DATA_W  instruction to the core
- `out_valid`  in  1  one-cycle pulse from the core: instruction retired
- `inst_addr`  in  ADDR_W  next PC from the core, valid with `out_valid`
- `mem_req`  out  1  instruction memory request
- `mem_addr`  out  ADDR_W  request address, word aligned
- `mem_ack`  in  1  one-cycle pulse: `mem_rdata` valid for the current request
- `mem_rdata`  in  DATA_W  read data
- `hit_cnt`  out  CNT_W  count of prefetch hits, saturating
- `err`  out  1  sticky protocol-error flag

## Operation
- States:
  - FETCH: `mem_req`=1, `mem_addr`=`pc`. On `mem_ack`: latch `mem_rdata`, go to ISSUE.
  - ISSUE: `in_valid`=1 for exactly one cycle, `inst`=latched word. Set `pf_addr`=`pc`+4 (mod 2^ADDR_W), go to PF.
  - PF: `mem_req`=1, `mem_addr`=`pf_addr`. An `out_valid` seen in PF is recorded as `pend`=1 with `npc`=`inst_addr`. On `mem_ack`: latch `pf_data`, then:
    - if `pend` is set: compare → hit: `pc`=`npc`, go to ISSUE with `pf_data`; miss: `pc`=`npc`, go to FETCH.
    - if `pend` is clear: go to HOLD.
    - If `out_valid` and `mem_ack` occur in the same cycle, treat it as `pend` already set.
  - HOLD: `mem_req`=0. On `out_valid`: if `inst_addr`==`pf_addr` (hit), `pc`=`inst_addr`, go to ISSUE with `pf_data`; otherwise (miss), `pc`=`inst_addr`, go to FETCH.
- A hit increments `hit_cnt`, saturating at all-ones; a miss does not.
- Memory protocol:
  - `mem_req` stays high with `mem_addr` stable until `mem_ack`.
  - `mem_ack` is ignored while `mem_req`=0.
  - Memory latency is arbitrary, at least 1 cycle.
- `err` is set by either of:
  - `out_valid` while in FETCH or ISSUE, or a second `out_valid` while `pend` is set; the extra pulse is ignored.
  - `inst_addr[1:0]`≠0 on `out_valid`; the address is used with the low bits forced to 0.
- `inst` holds its last value between pulses.

## Timing
- Reset values: `in_valid`=0, `inst`=0, `mem_req`=0, `mem_addr`=0, `hit_cnt`=0, `err`=0, state=FETCH, `pc`=`RESET_PC`, `pend`=0.
- First cycle after `rst` deasserts: `mem_req`=1, `mem_addr`=`RESET_PC`.
- Miss latency:
  - `mem_req` with the new address is high the cycle after `out_valid`, or the cycle after the prefetch ack if the decision happened in PF.
  - `in_valid` is high the cycle after `mem_ack`.
- Hit latency:
  - From HOLD: `in_valid` is high the cycle after `out_valid`.
  - From PF with `pend` set: `in_valid` is high the cycle after `mem_ack`.
- Address wrap: `pc`+4 from 0xFFFFFFFC gives 0x00000000.
- `rst` mid-request: all registers return to reset values at that edge and `mem_req` is low the following cycle. A late `mem_ack` is ignored because `mem_req` is 0.
- All outputs are registered.

## Test plan
- Reset, then memory latency 2 with word 0x0C010005 at address 0:
  - `mem_req` is high with `mem_addr`=0 in cycle 1.
  - `in_valid` pulses once with `inst`=0x0C010005 the cycle after ack.
- Sequential run:
  - Core returns `inst_addr`=4 while in HOLD → `in_valid` the next cycle with the word at address 4; `hit_cnt`=1.
  - Ten sequential instructions give `hit_cnt`=10.
- Branch miss:
  - Prefetch holds 0x8; core returns 0x40 → FETCH at 0x40 the cycle after `out_valid`, `hit_cnt` unchanged.
  - The instruction from 0x40 is delivered.
- Slow memory (latency 6), core returns 0x8 during PF:
  - `pend` is set; on ack, `in_valid` fires the next cycle with the prefetched data (hit).
  - With 0x20 returned instead, a FETCH of 0x20 follows.
- Protocol errors:
  - `out_valid` during FETCH → `err`=1, state unaffected.
  - `inst_addr`=0x6 → fetch address 0x4, `err`=1.
- `rst` asserted while `mem_req` is pending at 0x40:
  - `mem_req`=0 the next cycle; a stale `mem_ack` is ignored.
  - After release, the fetch restarts at `RESET_PC`.
